// File: rtl/snake_tick_scheduler.sv
// Avalon-MM master driving the snake game's interval timer; emits game ticks.
// Optional TICK_READBACK_EN verifies the programmed period by reading it back.
module snake_tick_scheduler #(
  parameter logic [31:0] BASE_PERIOD = 32'h0001D4BF,
  parameter logic [31:0] STEP        = 32'd8000,
  parameter logic [31:0] MIN_PERIOD  = 32'd19999,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pause,
  input  logic [3:0]       speed_level,
  input  logic             speed_update,
  output logic [2:0]       tmr_address,
  output logic             tmr_chipselect,
  output logic             tmr_write_n,
  output logic [15:0]      tmr_writedata,
  input  logic [15:0]      tmr_readdata,
  input  logic             tmr_irq,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             running,
  output logic             busy,
  output logic             cfg_error
);

  typedef enum logic [3:0] {
    S_IDLE, S_STOP, S_WR_PL, S_WR_PH, S_CLR, S_START, S_RUN,
    S_ACK, S_HALT, S_PAUSED, S_RB_L, S_RB_H, S_RB_CHK
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      period_q, period_d;
  logic             pend_q, pend_d;
  logic             halt_idle_q, halt_idle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             run_q, run_d;
  logic             busy_q, busy_d;
  logic             cs_q, cs_d;
  logic             wrn_q, wrn_d;
  logic [2:0]       addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic             retry_q, retry_d;
  logic             mm_q, mm_d;

  logic [31:0] dec, sub, calc;
  assign dec  = STEP * {28'd0, speed_level};
  assign sub  = BASE_PERIOD - dec;
  assign calc = (dec > BASE_PERIOD || sub < MIN_PERIOD) ? MIN_PERIOD : sub;

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    pend_d      = pend_q | speed_update;
    halt_idle_d = halt_idle_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    retry_d     = retry_q;
    mm_d        = mm_q;
    unique case (state_q)
      S_IDLE: begin
        retry_d = 1'b0;
        if (enable && !pause) state_d = S_STOP;
      end
      S_STOP:  state_d = S_WR_PL;
      S_WR_PL: state_d = S_WR_PH;
`ifdef TICK_READBACK_EN
      S_WR_PH: state_d = S_RB_L;
`else
      S_WR_PH: state_d = S_CLR;
`endif
      S_CLR:   state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (!enable) begin
          state_d     = S_HALT;
          halt_idle_d = 1'b1;
        end else if (tmr_irq) begin
          state_d = S_ACK;
        end else if (pause) begin
          state_d     = S_HALT;
          halt_idle_d = 1'b0;
        end else if (pend_q || speed_update) begin
          state_d = S_STOP;
          pend_d  = 1'b0;
        end
      end
      S_ACK:  state_d = S_RUN;
      S_HALT: state_d = halt_idle_q ? S_IDLE : S_PAUSED;
      S_PAUSED: begin
        if (!enable)    state_d = S_IDLE;
        else if (!pause) state_d = S_START;
      end
`ifdef TICK_READBACK_EN
      S_RB_L: state_d = S_RB_H;
      S_RB_H: begin
        mm_d    = tmr_readdata != period_q[15:0];
        state_d = S_RB_CHK;
      end
      S_RB_CHK: begin
        if (mm_q || tmr_readdata != period_q[31:16]) begin
          err_d   = 1'b1;
          retry_d = 1'b1;
          state_d = retry_q ? S_IDLE : S_STOP;
        end else begin
          retry_d = 1'b0;
          state_d = S_CLR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_STOP) period_d = calc;
    if (state_d == S_ACK) cnt_d = cnt_q + CNT_W'(1);
  end

  // Bus and status outputs are decoded from the next state so they register
  // in the same cycle the FSM enters that state.
  always_comb begin
    cs_d    = 1'b0;
    wrn_d   = 1'b1;
    addr_d  = 3'd0;
    wdata_d = 16'd0;
    unique case (state_d)
      S_STOP, S_HALT: begin
        cs_d = 1'b1; wrn_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0008;
      end
      S_WR_PL: begin
        cs_d = 1'b1; wrn_d = 1'b0; addr_d = 3'd2; wdata_d = period_q[15:0];
      end
      S_WR_PH: begin
        cs_d = 1'b1; wrn_d = 1'b0; addr_d = 3'd3; wdata_d = period_q[31:16];
      end
      S_CLR, S_ACK: begin
        cs_d = 1'b1; wrn_d = 1'b0;
      end
      S_START: begin
        cs_d = 1'b1; wrn_d = 1'b0; addr_d = 3'd1; wdata_d = 16'h0007;
      end
      S_RB_L: begin
        cs_d = 1'b1; addr_d = 3'd2;
      end
      S_RB_H: begin
        cs_d = 1'b1; addr_d = 3'd3;
      end
      default: ;
    endcase
    tick_d = state_d == S_ACK;
    run_d  = state_d == S_RUN || state_d == S_ACK;
    busy_d = !(state_d == S_IDLE || state_d == S_RUN || state_d == S_PAUSED);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      period_q    <= '0;
      pend_q      <= 1'b0;
      halt_idle_q <= 1'b0;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      cs_q        <= 1'b0;
      wrn_q       <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      retry_q     <= 1'b0;
      mm_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      pend_q      <= pend_d;
      halt_idle_q <= halt_idle_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      run_q       <= run_d;
      busy_q      <= busy_d;
      cs_q        <= cs_d;
      wrn_q       <= wrn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      retry_q     <= retry_d;
      mm_q        <= mm_d;
    end
  end

  assign tmr_address    = addr_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wrn_q;
  assign tmr_writedata  = wdata_q;
  assign tick           = tick_q;
  assign tick_count     = cnt_q;
  assign running        = run_q;
  assign busy           = busy_q;

`ifdef TICK_READBACK_EN
  assign cfg_error = err_q;
`else
  logic unused_rb;
  assign unused_rb = ^{tmr_readdata, err_q, retry_q, mm_q};
  assign cfg_error = 1'b0;
`endif

endmodule

// File: tb/tb_snake_tick_scheduler.sv
// Bench for snake_tick_scheduler: timer bus model plus transaction-level
// expectations of write sequences, ticks and status.
module tb_snake_tick_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        pause = 1'b0;
  logic [3:0]  speed_level = 4'd0;
  logic        speed_update = 1'b0;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata = 16'd0;
  logic        tmr_irq = 1'b0;
  logic        tick;
  logic [15:0] tick_count;
  logic        running;
  logic        busy;
  logic        cfg_error;

  snake_tick_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .pause          (pause),
    .speed_level    (speed_level),
    .speed_update   (speed_update),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_readdata   (tmr_readdata),
    .tmr_irq        (tmr_irq),
    .tick           (tick),
    .tick_count     (tick_count),
    .running        (running),
    .busy           (busy),
    .cfg_error      (cfg_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         wq[$];
  wr_t         eq[$];
  logic [15:0] regs [4] = '{default: 16'd0};
  int          raise_cnt = 0;
  int          seen_cnt = 0;
  int          rd2_cnt = 0;
  int          corrupt_until = 0;
  int          n_checks = 0;
  int          n_err = 0;
  int          model_cnt = 0;

  // Timer slave: records writes, registers reads, raises/clears the IRQ.
  always @(posedge clk) begin
    logic [15:0] rd;
    if (raise_cnt != seen_cnt) begin
      tmr_irq  <= 1'b1;
      seen_cnt <= raise_cnt;
    end
    if (tmr_chipselect && !tmr_write_n) begin
      regs[tmr_address[1:0]] <= tmr_writedata;
      wq.push_back('{tmr_address, tmr_writedata});
      if (tmr_address == 3'd0) tmr_irq <= 1'b0;
    end
    if (tmr_chipselect && tmr_write_n) begin
      rd = regs[tmr_address[1:0]];
      if (tmr_address == 3'd2) begin
        if (rd2_cnt < corrupt_until) rd = rd ^ 16'h0100;
        rd2_cnt <= rd2_cnt + 1;
      end
      tmr_readdata <= rd;
    end
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] model_period(int lvl);
    int p;
    p = 119999 - lvl * 8000;
    if (p < 19999) p = 19999;
    return p;
  endfunction

  function automatic void add_cfg(int lvl);
    logic [31:0] p;
    p = model_period(lvl);
    eq.push_back('{3'd1, 16'h0008});
    eq.push_back('{3'd2, p[15:0]});
    eq.push_back('{3'd3, p[31:16]});
  endfunction

  function automatic void add_prog(int lvl);
    add_cfg(lvl);
    eq.push_back('{3'd0, 16'h0000});
    eq.push_back('{3'd1, 16'h0007});
  endfunction

  task automatic expect_writes(string tag);
    check({tag, "_nwr"}, wq.size(), eq.size());
    for (int i = 0; i < eq.size(); i++)
      if (i < wq.size())
        check({tag, "_wr"}, {13'd0, wq[i]}, {13'd0, eq[i]});
    wq.delete();
    eq.delete();
  endtask

  task automatic wait_running(string tag);
    int k = 0;
    while (!running && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_running"}, running, 1'b1);
  endtask

  task automatic do_timeout();
    int k = 0;
    raise_cnt++;
    while (!tick && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("tick_seen", tick, 1'b1);
    model_cnt++;
    check("tick_count", tick_count, 32'(16'(model_cnt)));
    @(negedge clk);
    check("tick_width", tick, 1'b0);
    cyc(3);
    eq.push_back('{3'd0, 16'h0000});
    expect_writes("ack");
    check("run_after_ack", running, 1'b1);
  endtask

  task automatic run_round(int lvl, int ntime, bit do_pause, int newlvl);
    speed_level = 4'(lvl);
    enable = 1'b1;
    wait_running("start");
    add_prog(lvl);
    expect_writes("prog");
    check("busy_run", busy, 1'b0);
    for (int i = 0; i < ntime; i++) do_timeout();
    if (do_pause) begin
      raise_cnt++;
      @(posedge clk);
      #1 pause = 1'b1;
      cyc(8);
      model_cnt++;
      check("pause_tick_count", tick_count, 32'(16'(model_cnt)));
      check("paused_running", running, 1'b0);
      check("paused_busy", busy, 1'b0);
      eq.push_back('{3'd0, 16'h0000});
      eq.push_back('{3'd1, 16'h0008});
      expect_writes("pause");
      pause = 1'b0;
      wait_running("resume");
      eq.push_back('{3'd1, 16'h0007});
      expect_writes("resume");
    end
    speed_level = 4'(newlvl);
    speed_update = 1'b1;
    @(negedge clk);
    speed_update = 1'b0;
    @(negedge clk);
    wait_running("respeed");
    add_prog(newlvl);
    expect_writes("respeed");
    enable = 1'b0;
    cyc(4);
    eq.push_back('{3'd1, 16'h0008});
    expect_writes("disable");
    check("idle_running", running, 1'b0);
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    check("rst_cs", tmr_chipselect, 1'b0);
    check("rst_wrn", tmr_write_n, 1'b1);
    check("rst_addr", tmr_address, 3'd0);
    check("rst_wdata", tmr_writedata, 16'd0);
    check("rst_tick", tick, 1'b0);
    check("rst_count", tick_count, 16'd0);
    check("rst_running", running, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cfg_error", cfg_error, 1'b0);
    reset_n = 1'b1;
    cyc(2);

    run_round(0, 3, 1'b0, 15);
    run_round(15, 2, 1'b1, 3);
    for (int r = 0; r < 4; r++)
      run_round($urandom_range(0, 15), $urandom_range(1, 4),
                1'($urandom_range(0, 1)), $urandom_range(0, 15));

    // Second speed request lands while the first reprogram is in WR_PL.
    speed_level = 4'd1;
    enable = 1'b1;
    wait_running("mid_start");
    add_prog(1);
    expect_writes("mid_prog");
    speed_level = 4'd2;
    speed_update = 1'b1;
    @(negedge clk);
    speed_update = 1'b0;
    @(negedge clk);
    speed_level = 4'd4;
    speed_update = 1'b1;
    @(negedge clk);
    speed_update = 1'b0;
    cyc(20);
    check("mid_running", running, 1'b1);
    add_prog(2);
    add_prog(4);
    expect_writes("mid_reprog");
    enable = 1'b0;
    cyc(4);
    wq.delete();

    // Reset in the middle of a programming sequence.
    speed_level = 4'd5;
    enable = 1'b1;
    cyc(2);
    reset_n = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    check("mid_rst_cs", tmr_chipselect, 1'b0);
    check("mid_rst_wrn", tmr_write_n, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    model_cnt = 0;
    check("mid_rst_count", tick_count, 16'd0);
    reset_n = 1'b1;
    cyc(3);
    wq.delete();

`ifdef TICK_READBACK_EN
    begin
      int k;
      corrupt_until = rd2_cnt + 1;
      speed_level = 4'd0;
      enable = 1'b1;
      wait_running("rb1");
      check("rb1_cfg_error", cfg_error, 1'b1);
      add_cfg(0);
      add_prog(0);
      expect_writes("rb1");
      enable = 1'b0;
      cyc(4);
      wq.delete();
      corrupt_until = rd2_cnt + 100;
      enable = 1'b1;
      k = 0;
      while (!busy && k < 10) begin
        @(negedge clk);
        k++;
      end
      while (busy && k < 60) begin
        @(negedge clk);
        k++;
      end
      enable = 1'b0;
      check("rb2_busy", busy, 1'b0);
      cyc(2);
      check("rb2_running", running, 1'b0);
      check("rb2_cfg_error", cfg_error, 1'b1);
      add_cfg(0);
      add_cfg(0);
      expect_writes("rb2");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
